// File: rtl/wb_write_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Defines register-address and data types, the writeback request record,
// and a helper that turns a register address into a one-hot mask.
package wb_write_arbiter_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam int NUM_REGS = 32;

  typedef struct packed {
    reg_addr_t rd;
    word_t     data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] onehot_reg(input reg_addr_t r);
    onehot_reg = {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// In-order queue of load writebacks (wb_fifo).
// The read data is always the current head entry (show-ahead).
// A push while full and a pop while empty are both ignored.
module wb_write_arbiter_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_req_t       push_data,
  input  logic          pop,
  output wb_req_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_req_t       mem_q [DEPTH];
  wb_req_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer and count registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter.
// Merges the unstallable ALU writeback with load responses, queues loads that
// lose arbitration, and tracks destinations of outstanding loads.
// Optional feature: define WB_BYPASS_EN to add the write-port bypass taps.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [31:0]                   alu_data,
  input  logic                          ld_issue,
  input  logic [4:0]                    ld_issue_rd,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [4:0]                    ld_rd,
  input  logic [31:0]                   ld_data,
  output logic [4:0]                    rf_write_reg,
  output logic [31:0]                   rf_write_data,
  output logic                          rf_writeEnable,
  output logic [31:0]                   pending,
`ifdef WB_BYPASS_EN
  input  logic [4:0]                    byp_rs1,
  input  logic [4:0]                    byp_rs2,
  output logic                          byp_hit1,
  output logic                          byp_hit2,
  output logic [31:0]                   byp_data1,
  output logic [31:0]                   byp_data2,
`endif
  output logic [$clog2(LQ_DEPTH+1)-1:0] lq_count
);

  wb_req_t     lq_head;
  logic        lq_full, lq_empty, lq_push, lq_pop;
  logic        ld_acc;
  logic        win_valid, win_is_ld;
  wb_req_t     win_req;
  logic [31:0] pend_set, pend_clr;

  logic [4:0]  rf_write_reg_q, rf_write_reg_d;
  logic [31:0] rf_write_data_q, rf_write_data_d;
  logic        rf_we_q, rf_we_d;
  logic [31:0] pending_q, pending_d;

  // Readiness comes only from registered occupancy, so a full queue refuses
  // a push even in a cycle where it drains.
  assign ld_ready = !rst && !lq_full;
  assign ld_acc   = ld_valid && ld_ready;
  assign lq_pop   = !alu_valid && !lq_empty;
  assign lq_push  = ld_acc && !(lq_empty && !alu_valid);

  wb_write_arbiter_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .rst       (rst),
    .push      (lq_push),
    .push_data ('{rd: ld_rd, data: ld_data}),
    .pop       (lq_pop),
    .head      (lq_head),
    .full      (lq_full),
    .empty     (lq_empty),
    .count     (lq_count)
  );

  // Pick this cycle's writer: ALU, then queue head, then a fresh load (fast path).
  always_comb begin
    win_valid = 1'b0;
    win_is_ld = 1'b0;
    win_req   = '0;
    if (alu_valid) begin
      win_valid = 1'b1;
      win_req   = '{rd: alu_rd, data: alu_data};
    end else if (!lq_empty) begin
      win_valid = 1'b1;
      win_is_ld = 1'b1;
      win_req   = lq_head;
    end else if (ld_acc) begin
      win_valid = 1'b1;
      win_is_ld = 1'b1;
      win_req   = '{rd: ld_rd, data: ld_data};
    end
  end

  // Next write-port value and pending bitmap; an issue beats a same-cycle clear.
  always_comb begin
    rf_write_reg_d  = rf_write_reg_q;
    rf_write_data_d = rf_write_data_q;
    rf_we_d         = win_valid && (win_req.rd != '0);
    if (win_valid) begin
      rf_write_reg_d  = win_req.rd;
      rf_write_data_d = win_req.data;
    end
    pend_clr  = (win_valid && win_is_ld) ? onehot_reg(win_req.rd) : '0;
    pend_set  = (ld_issue && ld_issue_rd != '0) ? onehot_reg(ld_issue_rd) : '0;
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  // Write-port and pending registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
      rf_we_q         <= 1'b0;
      pending_q       <= '0;
    end else begin
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
      rf_we_q         <= rf_we_d;
      pending_q       <= pending_d;
    end
  end

  assign rf_write_reg   = rf_write_reg_q;
  assign rf_write_data  = rf_write_data_q;
  assign rf_writeEnable = rf_we_q;
  assign pending        = pending_q;

`ifdef WB_BYPASS_EN
  assign byp_hit1  = rf_we_q && (rf_write_reg_q == byp_rs1) && (byp_rs1 != '0);
  assign byp_hit2  = rf_we_q && (rf_write_reg_q == byp_rs2) && (byp_rs2 != '0);
  assign byp_data1 = rf_write_data_q;
  assign byp_data2 = rf_write_data_q;
`endif

  // Upstream protocol checks; x0 loads are never tracked so they are exempt.
  a_issue_not_pending: assert property (@(posedge clk) disable iff (rst)
    !(ld_issue && pending_q[ld_issue_rd]));
  a_alu_not_pending: assert property (@(posedge clk) disable iff (rst)
    !(alu_valid && pending_q[alu_rd]));
  a_load_was_issued: assert property (@(posedge clk) disable iff (rst)
    !(ld_valid && ld_rd != '0 && !pending_q[ld_rd]));

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_writeEnable;
  logic [31:0] pending;
  logic [2:0]  lq_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_rs1, byp_rs2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
`endif

  int tests = 0;
  int fails = 0;
  wb_req_t exp_q[$];

  always #5 clk = ~clk;

  wb_write_arbiter #(.LQ_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .rf_write_reg   (rf_write_reg),
    .rf_write_data  (rf_write_data),
    .rf_writeEnable (rf_writeEnable),
    .pending        (pending),
`ifdef WB_BYPASS_EN
    .byp_rs1        (byp_rs1),
    .byp_rs2        (byp_rs2),
    .byp_hit1       (byp_hit1),
    .byp_hit2       (byp_hit2),
    .byp_data1      (byp_data1),
    .byp_data2      (byp_data2),
`endif
    .lq_count       (lq_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{rd: rd, data: data});
  endtask

  // Monitor: every regFile write is matched against the next expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rf_writeEnable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {27'd0, rf_write_reg}, 32'hFFFF_FFFF);
        end else begin
          wb_req_t e;
          e = exp_q.pop_front();
          check("wr_reg", {27'd0, rf_write_reg}, {27'd0, e.rd});
          check("wr_data", rf_write_data, e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
`ifdef WB_BYPASS_EN
    byp_rs1 = 0; byp_rs2 = 0;
`endif
    // 1 reset
    tick();
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_we", {31'd0, rf_writeEnable}, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_lq_count", {29'd0, lq_count}, 32'd0);
    tick();
    check("rst_ld_ready2", {31'd0, ld_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ld_ready", {31'd0, ld_ready}, 32'd1);

    // 2 ALU write, one cycle only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
    expect_wr(5, 32'hDEAD_BEEF);
    tick();
    alu_valid = 0;
    check("alu_we", {31'd0, rf_writeEnable}, 32'd1);
    tick();
    check("alu_we_once", {31'd0, rf_writeEnable}, 32'd0);

    // 3 load fast path
    ld_issue = 1; ld_issue_rd = 7;
    tick();
    ld_issue = 0;
    check("pend7_set", pending, 32'h0000_0080);
    tick();
    check("pend7_hold", pending, 32'h0000_0080);
    ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
    expect_wr(7, 32'h1234);
    tick();
    ld_valid = 0;
    check("pend7_clr", pending, 32'd0);
    check("fast_lq_count", {29'd0, lq_count}, 32'd0);
`ifdef WB_BYPASS_EN
    byp_rs1 = 7; byp_rs2 = 8;
    #1;
    check("byp_hit1", {31'd0, byp_hit1}, 32'd1);
    check("byp_data1", byp_data1, 32'h1234);
    check("byp_hit2", {31'd0, byp_hit2}, 32'd0);
    byp_rs1 = 0; byp_rs2 = 0;
`endif
    tick();

    // 4 conflict: ALU x3 and load x9 in the same cycle
    ld_issue = 1; ld_issue_rd = 9;
    tick();
    ld_issue = 0;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h333;
    ld_valid = 1; ld_rd = 9; ld_data = 32'h999;
    expect_wr(3, 32'h333);
    expect_wr(9, 32'h999);
    tick();
    alu_valid = 0; ld_valid = 0;
    check("conf_lq1", {29'd0, lq_count}, 32'd1);
    check("conf_pend9", pending, 32'h0000_0200);
    tick();
    check("conf_lq0", {29'd0, lq_count}, 32'd0);
    check("conf_pend_clr", pending, 32'd0);

    // 5 full queue under sustained ALU traffic
    for (int i = 0; i < 5; i++) begin
      ld_issue = 1; ld_issue_rd = 5'(10 + i);
      tick();
    end
    ld_issue = 0;
    check("full_pend", pending, 32'h0000_7C00);
    for (int k = 0; k < 6; k++) begin
      alu_valid = 1; alu_rd = 5'(20 + k); alu_data = 32'hA0 + k;
      expect_wr(5'(20 + k), 32'hA0 + k);
      ld_valid = 1;
      ld_rd = (k < 4) ? 5'(10 + k) : 5'd14;
      ld_data = 32'h100 + ld_rd;
      if (k < 4) begin
        check("full_ready_hi", {31'd0, ld_ready}, 32'd1);
      end else begin
        check("full_ready_lo", {31'd0, ld_ready}, 32'd0);
        check("full_lq4", {29'd0, lq_count}, 32'd4);
      end
      tick();
    end
    alu_valid = 0; ld_valid = 0;
    for (int i = 0; i < 4; i++) expect_wr(5'(10 + i), 32'h10A + i);
    tick();
    check("drain_lq3", {29'd0, lq_count}, 32'd3);
    tick(); tick(); tick();
    check("drain_lq0", {29'd0, lq_count}, 32'd0);
    check("drain_pend14", pending, 32'h0000_4000);
    ld_valid = 1; ld_rd = 14; ld_data = 32'h10E;
    expect_wr(14, 32'h10E);
    tick();
    ld_valid = 0;
    check("pend14_clr", pending, 32'd0);

    // 6 rd = 0 loads: fast path, then through the queue
    ld_valid = 1; ld_rd = 0; ld_data = 32'hFFFF;
    check("rd0_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 0;
    check("rd0_we", {31'd0, rf_writeEnable}, 32'd0);
    check("rd0_pend", pending, 32'd0);
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    ld_valid = 1; ld_rd = 0; ld_data = 32'h22;
    expect_wr(1, 32'h11);
    tick();
    alu_valid = 0; ld_valid = 0;
    check("rd0q_lq1", {29'd0, lq_count}, 32'd1);
    tick();
    check("rd0q_lq0", {29'd0, lq_count}, 32'd0);
    check("rd0q_we", {31'd0, rf_writeEnable}, 32'd0);

    tick(); tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
